// File: rtl/preg_accum.sv
`default_nettype none
// ============================================================================
//  Module   : preg_accum
//  Purpose  : Accumulates carry-save coefficient terms at a coefficient offset
//             into a 2*NCOEF wide accumulator, then normalises each
//             coefficient into a DW+1 bit digit with one step of carry.
//  Revision : 1.0  initial release
// ============================================================================
module preg_accum #(
    parameter int NCOEF = 66,
    parameter int CW    = 25,
    parameter int DW    = 16,
    parameter int ACW   = 30,
    parameter int MAXT  = 16
) (
    input  logic                           clk_sq,
    input  logic                           reset_sq,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NCOEF*CW-1:0]            in_c,
    input  logic [NCOEF*CW-1:0]            in_s,
    input  logic [$clog2(NCOEF+2)-1:0]     in_off,
    input  logic                           in_dbl,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*NCOEF*(DW+1)-1:0]      out_digit,
    output logic                           out_err,
    output logic                           out_ovf
);

    localparam int NACC = 2 * NCOEF;
    localparam int CNTW = $clog2(MAXT + 1);
    localparam int AIW  = $clog2(NACC);
    localparam int TW   = CW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        NORM = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ACW-1:0]           acc_q [NACC];
    logic [ACW-1:0]           acc_d [NACC];
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     out_valid_q, out_valid_d;
    logic [NACC*(DW+1)-1:0]   out_digit_q, out_digit_d;
    logic                     out_err_q, out_err_d;
    logic                     out_ovf_q, out_ovf_d;

    logic [TW-1:0]            term [NCOEF];
    logic [CW:0]              pair_sum;
    logic                     accept;
    logic                     drop;
    logic [AIW-1:0]           idx;
    logic [DW:0]              digit;

    // Resolve each carry-save pair into one term coefficient, optionally doubled
    always_comb begin
        pair_sum = '0;
        for (int i = 0; i < NCOEF; i++) begin
            pair_sum = {1'b0, in_c[i*CW +: CW]} + {1'b0, in_s[i*CW +: CW]};
            term[i]  = in_dbl ? {pair_sum, 1'b0} : {1'b0, pair_sum};
        end
    end

    // Handshake, drop qualification and next-state / datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_err_d   = out_err_q;
        out_ovf_d   = out_ovf_q;
        idx         = '0;
        digit       = '0;
        for (int j = 0; j < NACC; j++) begin
            acc_d[j] = acc_q[j];
        end

        in_ready = (state_q == IDLE) || (state_q == ACC);
        accept   = in_valid && in_ready;
        // A full term counter or an offset past the top coefficient drops the term
        drop     = (cnt_q == CNTW'(MAXT)) || (int'(in_off) > NCOEF);

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    // First term of an accumulation starts from a clean slate
                    if (state_q == IDLE) begin
                        for (int j = 0; j < NACC; j++) begin
                            acc_d[j] = '0;
                        end
                    end
                    if (drop) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        for (int i = 0; i < NCOEF; i++) begin
                            idx        = AIW'(i) + AIW'(in_off);
                            acc_d[idx] = acc_d[idx] + ACW'(term[i]);
                        end
                    end
                    state_d = in_last ? NORM : ACC;
                end
            end
            NORM: begin
                // Single carry step: low DW bits plus the high part of the coefficient below
                for (int m = 0; m < NACC; m++) begin
                    digit = {1'b0, acc_q[m][DW-1:0]};
                    if (m > 0) begin
                        digit = digit + (DW+1)'(acc_q[m-1][ACW-1:DW]);
                    end
                    out_digit_d[m*(DW+1) +: DW+1] = digit;
                end
                out_err_d   = err_q;
                out_ovf_d   = |acc_q[NACC-1][ACW-1:DW];
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk_sq or negedge reset_sq) begin
        if (!reset_sq) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_err_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
            for (int j = 0; j < NACC; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_err_q   <= out_err_d;
            out_ovf_q   <= out_ovf_d;
            for (int j = 0; j < NACC; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_err   = out_err_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_preg_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preg_accum
//  Purpose  : Directed self-checking bench for preg_accum
//  Revision : 1.0  initial release
// ============================================================================
module tb_preg_accum;

    localparam int NCOEF = 66;
    localparam int CW    = 25;
    localparam int DW    = 16;
    localparam int ACW   = 30;
    localparam int MAXT  = 16;
    localparam int NACC  = 2 * NCOEF;
    localparam int OW    = $clog2(NCOEF + 2);

    logic                        clk_sq = 1'b0;
    logic                        reset_sq;
    logic                        in_valid;
    logic                        in_ready;
    logic [NCOEF*CW-1:0]         in_c;
    logic [NCOEF*CW-1:0]         in_s;
    logic [OW-1:0]               in_off;
    logic                        in_dbl;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [NACC*(DW+1)-1:0]      out_digit;
    logic                        out_err;
    logic                        out_ovf;

    int tests = 0;
    int fails = 0;

    preg_accum #(
        .NCOEF(NCOEF), .CW(CW), .DW(DW), .ACW(ACW), .MAXT(MAXT)
    ) dut (
        .clk_sq(clk_sq), .reset_sq(reset_sq),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_s(in_s), .in_off(in_off), .in_dbl(in_dbl), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_digit(out_digit), .out_err(out_err), .out_ovf(out_ovf)
    );

    always #5 clk_sq = ~clk_sq;

    task automatic step();
        @(posedge clk_sq);
        #1;
    endtask

    function automatic logic [DW:0] dig(input int m);
        return out_digit[m*(DW+1) +: DW+1];
    endfunction

    // Offer one term for exactly one cycle; inputs idle afterwards
    task automatic send_term(input int ci, input logic [CW-1:0] cv,
                             input int si, input logic [CW-1:0] sv,
                             input logic [OW-1:0] off, input logic dbl, input logic last);
        in_c = '0;
        in_s = '0;
        in_c[ci*CW +: CW] = cv;
        in_s[si*CW +: CW] = sv;
        in_off   = off;
        in_dbl   = dbl;
        in_last  = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_c     = '0;
        in_s     = '0;
        in_off   = '0;
        in_dbl   = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_sq = 1'b0;
        repeat (2) step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (out_digit !== '0) begin fails++; $display("FAIL reset_out_digit got=%h exp=0", dig(0)); end
        tests++; if (out_err !== 1'b0 || out_ovf !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", out_err, out_ovf); end
        reset_sq = 1'b1;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        int bad;
        send_term(0, 25'h10000, 0, 25'h00001, '0, 1'b0, 1'b1);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL single_norm got=v%b r%b exp=v0 r0", out_valid, in_ready); end
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_latency got=%b exp=1", out_valid); end
        tests++; if (dig(0) !== 17'h00001) begin fails++; $display("FAIL single_d0 got=%h exp=00001", dig(0)); end
        tests++; if (dig(1) !== 17'h00001) begin fails++; $display("FAIL single_d1 got=%h exp=00001", dig(1)); end
        bad = 0;
        for (int m = 2; m < NACC; m++) if (dig(m) !== '0) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL single_others got=%0d nonzero exp=0", bad); end
        tests++; if (out_err !== 1'b0 || out_ovf !== 1'b0) begin fails++; $display("FAIL single_flags got=%b%b exp=00", out_err, out_ovf); end
        consume();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL single_release got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        tests++; if (dig(0) !== 17'h00001) begin fails++; $display("FAIL single_keep got=%h exp=00001", dig(0)); end
    endtask

    task automatic test_two_terms();
        out_ready = 1'b1;  // must be ignored while accumulating
        send_term(0, 25'h0FFFF, 0, 25'h0, 7'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        send_term(0, 25'h00001, 0, 25'h0, 7'd1, 1'b1, 1'b1);
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL two_valid got=%b exp=1", out_valid); end
        tests++; if (dig(0) !== 17'h0FFFF) begin fails++; $display("FAIL two_d0 got=%h exp=0ffff", dig(0)); end
        tests++; if (dig(1) !== 17'h00002) begin fails++; $display("FAIL two_d1 got=%h exp=00002", dig(1)); end
        tests++; if (dig(2) !== 17'h0) begin fails++; $display("FAIL two_d2 got=%h exp=0", dig(2)); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL two_err got=%b exp=0", out_err); end
        consume();
    endtask

    task automatic test_maxt();
        for (int k = 0; k <= MAXT; k++) begin
            send_term(0, 25'h0, 0, 25'h1, 7'd0, 1'b0, (k == MAXT));
        end
        step();
        tests++; if (dig(0) !== 17'(MAXT)) begin fails++; $display("FAIL maxt_d0 got=%0d exp=%0d", dig(0), MAXT); end
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL maxt_err got=%b exp=1", out_err); end
        consume();
    endtask

    task automatic test_bad_off();
        int bad;
        send_term(0, 25'h1234, 0, 25'h1, 7'(NCOEF + 1), 1'b0, 1'b1);
        step();
        bad = 0;
        for (int m = 0; m < NACC; m++) if (dig(m) !== '0) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL badoff_digits got=%0d nonzero exp=0", bad); end
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL badoff_err got=%b exp=1", out_err); end
        consume();
    endtask

    task automatic test_ovf();
        // 0x8000 doubled lands 0x10000 in the top accumulator coefficient
        send_term(NCOEF - 1, 25'h08000, 0, 25'h0, 7'(NCOEF), 1'b1, 1'b1);
        step();
        tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
        tests++; if (dig(NACC - 1) !== 17'h0) begin fails++; $display("FAIL ovf_top got=%h exp=0", dig(NACC - 1)); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL ovf_err got=%b exp=0", out_err); end
        consume();
        send_term(0, 25'h0, 0, 25'h2, 7'd0, 1'b0, 1'b1);
        step();
        tests++; if (out_ovf !== 1'b0 || dig(0) !== 17'h2) begin fails++; $display("FAIL ovf_clear got=%b/%h exp=0/00002", out_ovf, dig(0)); end
        consume();
    endtask

    task automatic test_backpressure();
        send_term(0, 25'h0, 0, 25'h1234, 7'd0, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            in_s[0 +: CW] = 25'hFFFF;
            in_last  = 1'b1;
            in_valid = 1'b1;
            step();
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dig(0) !== 17'h1234 || dig(1) !== 17'h0 || out_err !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d got=r%b v%b d0=%h d1=%h e%b exp=r0 v1 d0=01234 d1=0 e0", k, in_ready, out_valid, dig(0), dig(1), out_err);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_s     = '0;
        consume();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        send_term(0, 25'h0, 0, 25'h3, 7'd0, 1'b0, 1'b1);
        step();
        tests++; if (dig(0) !== 17'h3) begin fails++; $display("FAIL hold_next got=%h exp=00003", dig(0)); end
        consume();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) send_term(0, 25'h0, 0, 25'h5, 7'd0, 1'b0, 1'b0);
        #2;
        reset_sq = 1'b0;
        #1;
        tests++; if (out_digit !== '0) begin fails++; $display("FAIL rstmid_digits got=%h exp=0", dig(0)); end
        tests++; if (out_valid !== 1'b0 || out_err !== 1'b0 || out_ovf !== 1'b0) begin fails++; $display("FAIL rstmid_flags got=%b%b%b exp=000", out_valid, out_err, out_ovf); end
        #1;
        reset_sq = 1'b1;
        step();
        send_term(0, 25'h0, 0, 25'h7, 7'd0, 1'b0, 1'b1);
        step();
        tests++; if (out_valid !== 1'b1 || dig(0) !== 17'h7) begin fails++; $display("FAIL rstmid_fresh got=v%b d0=%h exp=v1 d0=00007", out_valid, dig(0)); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL rstmid_err got=%b exp=0", out_err); end
        consume();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_c      = '0;
        in_s      = '0;
        in_off    = '0;
        in_dbl    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_two_terms();
        test_maxt();
        test_bad_off();
        test_ovf();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
